// File: rtl/dodge_game_engine.sv
// rtl/dodge_game_engine.sv - dodge game core: obstacles, player, collision, score, IDLE/PLAY/OVER (optional DODGE_LIVES_EN)
module dodge_game_engine #(
  parameter int          NUM_OBJ   = 4,
  parameter int          FIELD_W   = 192,
  parameter int          FIELD_H   = 930,
  parameter int          X_W       = 9,
  parameter int          Y_W       = 11,
  parameter int          OBJ_HW    = 5,
  parameter int          OBJ_HH    = 50,
  parameter int          PL_HW     = 5,
  parameter int          PL_HH     = 50,
  parameter int          PL_STEP   = 5,
  parameter int          BASE_SPD  = 5,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef DODGE_LIVES_EN
  , parameter int        LIVES     = 3
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mv,
  input  logic                     btn_left,
  input  logic                     btn_right,
  output logic [NUM_OBJ*X_W-1:0]   obj_x,
  output logic [NUM_OBJ*Y_W-1:0]   obj_y,
  output logic [X_W-1:0]           player_x,
  output logic [Y_W-1:0]           player_y,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       best_score,
  output logic [1:0]               state,
  output logic                     game_over
`ifdef DODGE_LIVES_EN
  , output logic [2:0]             lives
`endif
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_OVER = 2'b10;

  localparam logic [Y_W+1:0]     FH       = (Y_W+2)'(FIELD_H);
  localparam logic [X_W+1:0]     XMIN     = (X_W+2)'(PL_HW);
  localparam logic [X_W+1:0]     XMAX     = (X_W+2)'(FIELD_W - PL_HW);
  localparam logic [X_W+1:0]     STEP     = (X_W+2)'(PL_STEP);
  localparam logic [X_W-1:0]     HIT_X    = X_W'(PL_HW + OBJ_HW);
  localparam logic [Y_W-1:0]     HIT_Y    = Y_W'(PL_HH + OBJ_HH);
  localparam logic [Y_W-1:0]     PLAYER_Y = Y_W'(FIELD_H - 1);
  localparam logic [Y_W-1:0]     START_Y  = Y_W'(100);
  localparam logic [SCORE_W+3:0] SMAX     = {4'b0, {SCORE_W{1'b1}}};

  logic [X_W-1:0]     ox [NUM_OBJ];
  logic [Y_W-1:0]     oy [NUM_OBJ];
  logic [X_W-1:0]     ox_mv [NUM_OBJ];
  logic [Y_W-1:0]     oy_mv [NUM_OBJ];
  logic [Y_W+1:0]     y_sum;
  logic [3:0]         nwrap;
  logic [SCORE_W+3:0] score_sum;
  logic [SCORE_W-1:0] score_mv;
  logic [X_W+1:0]     px_next;
  logic [X_W-1:0]     player_mv;
  logic [X_W-1:0]     dx;
  logic [Y_W-1:0]     dy;
  logic               hit;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;

  // Evenly spaced starting columns for the obstacles
  function automatic logic [X_W-1:0] init_x(input int idx);
    return X_W'(FIELD_W * (2*idx + 1) / (2*NUM_OBJ));
  endfunction

  // Respawn column from an 8-bit window of the LFSR, scaled into the field
  function automatic logic [X_W-1:0] spawn_x(input int idx, input logic [15:0] l);
    logic [7:0]  r;
    logic [31:0] p;
    for (int k = 0; k < 8; k++) r[k] = l[4'(2*idx + k)];
    p = 32'(r) * 32'(FIELD_W - 2*OBJ_HW);
    return X_W'(32'(OBJ_HW) + (p >> 8));
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_OBJ; g++) begin : g_pack
      assign obj_x[g*X_W +: X_W] = ox[g];
      assign obj_y[g*Y_W +: Y_W] = oy[g];
    end
  endgenerate

  assign player_y = PLAYER_Y;

  // Next-step positions, wrap count, saturating score, collision and LFSR step
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    nwrap     = '0;
    hit       = 1'b0;
    y_sum     = '0;
    dx        = '0;
    dy        = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      y_sum = {2'b00, oy[i]} + (Y_W+2)'(BASE_SPD*(i+1)) + (Y_W+2)'({score, 1'b0});
      if (y_sum >= FH) begin
        oy_mv[i] = '0;
        ox_mv[i] = spawn_x(i, lfsr);
        nwrap    = nwrap + 4'd1;
      end else begin
        oy_mv[i] = y_sum[Y_W-1:0];
        ox_mv[i] = ox[i];
      end
      dx = (player_x >= ox[i]) ? player_x - ox[i] : ox[i] - player_x;
      dy = (PLAYER_Y >= oy[i]) ? PLAYER_Y - oy[i] : oy[i] - PLAYER_Y;
      if (dx <= HIT_X && dy <= HIT_Y) hit = 1'b1;
    end
    score_sum = {4'b0, score} + {{SCORE_W{1'b0}}, nwrap};
    score_mv  = (score_sum > SMAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    px_next = {2'b00, player_x};
    if (btn_left && !btn_right)
      px_next = (px_next < XMIN + STEP) ? XMIN : px_next - STEP;
    else if (btn_right && !btn_left)
      px_next = px_next + STEP;
    if (px_next > XMAX) px_next = XMAX;
    if (px_next < XMIN) px_next = XMIN;
    player_mv = px_next[X_W-1:0];
  end

  // Game state machine, positions, score and LFSR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      score      <= '0;
      best_score <= '0;
      game_over  <= 1'b0;
      lfsr       <= LFSR_SEED;
      player_x   <= X_W'(FIELD_W/2);
      for (int i = 0; i < NUM_OBJ; i++) begin
        ox[i] <= init_x(i);
        oy[i] <= START_Y;
      end
`ifdef DODGE_LIVES_EN
      lives      <= 3'(LIVES);
`endif
    end else begin
      lfsr      <= lfsr_next;
      game_over <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state    <= S_PLAY;
            score    <= '0;
            player_x <= X_W'(FIELD_W/2);
            for (int i = 0; i < NUM_OBJ; i++) begin
              ox[i] <= init_x(i);
              oy[i] <= START_Y;
            end
`ifdef DODGE_LIVES_EN
            lives    <= 3'(LIVES);
`endif
          end
        end
        S_PLAY: begin
          // A hit takes priority over a coincident mv: positions freeze
          if (hit) begin
`ifdef DODGE_LIVES_EN
            if (lives > 3'd1) begin
              lives <= lives - 3'd1;
              for (int i = 0; i < NUM_OBJ; i++) begin
                oy[i] <= '0;
                ox[i] <= spawn_x(i, lfsr);
              end
            end else begin
              lives     <= 3'd0;
              state     <= S_OVER;
              game_over <= 1'b1;
              if (score > best_score) best_score <= score;
            end
`else
            state     <= S_OVER;
            game_over <= 1'b1;
            if (score > best_score) best_score <= score;
`endif
          end else if (mv) begin
            score    <= score_mv;
            player_x <= player_mv;
            for (int i = 0; i < NUM_OBJ; i++) begin
              ox[i] <= ox_mv[i];
              oy[i] <= oy_mv[i];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dodge_game_engine.sv
// tb/tb_dodge_game_engine.sv - directed self-checking bench for dodge_game_engine
module tb_dodge_game_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, mv, btn_left, btn_right;
  logic [35:0] obj_x;
  logic [43:0] obj_y;
  logic [8:0]  player_x;
  logic [10:0] player_y;
  logic [7:0]  score, best_score;
  logic [1:0]  state;
  logic        game_over;
`ifdef DODGE_LIVES_EN
  logic [2:0]  lives;
`endif

  int total = 0;
  int bad   = 0;
  int my [4];
  int msc;
  int mbest;
  bit reached;

  dodge_game_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mv(mv),
    .btn_left(btn_left), .btn_right(btn_right),
    .obj_x(obj_x), .obj_y(obj_y), .player_x(player_x), .player_y(player_y),
    .score(score), .best_score(best_score), .state(state), .game_over(game_over)
`ifdef DODGE_LIVES_EN
    , .lives(lives)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int oyv(input int i);
    return int'(obj_y[i*11 +: 11]);
  endfunction

  function automatic int oxv(input int i);
    return int'(obj_x[i*9 +: 9]);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(negedge clk) mv = 1'b1;
    @(posedge clk); #1 mv = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) my[i] = 100;
    msc = 0;
  endtask

  task automatic model_tick();
    int w;
    int ny;
    w = 0;
    for (int i = 0; i < 4; i++) begin
      ny = my[i] + 5*(i+1) + 2*msc;
      if (ny >= 930) begin my[i] = 0; w++; end
      else my[i] = ny;
    end
    msc = (msc + w > 255) ? 255 : msc + w;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, 32'(state), 0);
    chk({pfx, "_px"}, 32'(player_x), 96);
    chk({pfx, "_py"}, 32'(player_y), 929);
    chk({pfx, "_score"}, 32'(score), 0);
    chk({pfx, "_best"}, 32'(best_score), 0);
    chk({pfx, "_gover"}, 32'(game_over), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_ox%0d", pfx, i), oxv(i), 24 + 48*i);
      chk($sformatf("%s_oy%0d", pfx, i), oyv(i), 100);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mv = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // T1 reset values
    chk_reset_vals("t1");

    // T2 start and one mv
    pulse_start();
    chk("t2_state", 32'(state), 1);
    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("t2_oy%0d", i), oyv(i), 100 + 5*(i+1));
    chk("t2_px", 32'(player_x), 96);
    pulse_start();
    chk("t2_start_ign_state", 32'(state), 1);
    chk("t2_start_ign_oy0", oyv(0), 105);

    // T4 move left then collide with obstacle 1
    do_reset();
    pulse_start();
    model_reset();
    btn_left = 1'b1;
    repeat (5) begin tick(); model_tick(); end
    btn_left = 1'b0;
    chk("t4_px", 32'(player_x), 71);
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick(); model_tick();
      if (my[1] >= 829) begin reached = 1'b1; break; end
    end
    chk("t4_reached", 32'(reached), 1);
    chk("t4_pre_state", 32'(state), 1);
    chk("t4_pre_gover", 32'(game_over), 0);
    chk("t4_oy1", oyv(1), my[1]);
    chk("t4_score", 32'(score), msc);
    step();
    chk("t4_over_state", 32'(state), 2);
    chk("t4_over_gover", 32'(game_over), 1);
    chk("t4_best", 32'(best_score), msc);
    step();
    chk("t4_gover_clear", 32'(game_over), 0);
    chk("t4_state_hold", 32'(state), 2);
    tick();
    chk("t4_frozen_oy1", oyv(1), my[1]);
    chk("t4_frozen_score", 32'(score), msc);
    mbest = msc;

    // T3 restart from OVER, run to first wrap of obstacle 3
    pulse_start();
    chk("t3_state", 32'(state), 1);
    chk("t3_score0", 32'(score), 0);
    chk("t3_best_kept", 32'(best_score), mbest);
    chk("t3_oy3_reload", oyv(3), 100);
    repeat (41) tick();
    chk("t3_oy3_41", oyv(3), 920);
    chk("t3_score_41", 32'(score), 0);
    tick();
    chk("t3_oy3_wrap", oyv(3), 0);
    chk("t3_ox3_range", 32'((oxv(3) >= 5) && (oxv(3) <= 187)), 1);
    chk("t3_score_1", 32'(score), 1);
    chk("t3_oy0", oyv(0), 310);
    chk("t3_oy1", oyv(1), 520);
    chk("t3_oy2", oyv(2), 730);

    // T6 asynchronous reset mid-game
    chk("t6_best_pre", 32'(best_score), mbest);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_reset_vals("t6");
    @(negedge clk) rst_n = 1'b1;

    // T5 player clamp and both-button hold
    pulse_start();
    btn_left = 1'b1;
    repeat (30) tick();
    chk("t5_clamp_lo", 32'(player_x), 5);
    btn_right = 1'b1;
    repeat (3) tick();
    chk("t5_both_hold", 32'(player_x), 5);
    btn_left = 1'b0;
    tick();
    chk("t5_right", 32'(player_x), 10);
    btn_right = 1'b0;
    chk("t5_state", 32'(state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
